uart_bytes_rx: RTL

Serial receiver and packet deframer for the board-to-core UART load path. It is the receive side of the multi-word packet format used by the design's UART transmit path. It recovers 12-bit UART words from the `rx` pin and checks for a handshake word followed by BYTE_COUNT data words. It presents the reassembled 42-bit `{target_mem, target_addr[8:0], data[31:0]}` record to the memory loader with a one-cycle valid strobe.

---
 rtl/uart_bytes_rx.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_bytes_rx.sv
// rtl/uart_bytes_rx.sv - UART word receiver and packet deframer; optional inter-word timeout via UART_BYTES_RX_TIMEOUT_EN.
module uart_bytes_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 12,
    parameter int BYTE_COUNT   = 4,
    parameter int TIMEOUT_CLKS = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic [41:0] data_out,
    output logic        valid,
    output logic        error,
    output logic        busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [2:0]       K_LAST    = 3'(BYTE_COUNT - 1);

    typedef enum logic [1:0] {W_IDLE, W_START, W_DATA, W_STOP} w_state_t;
    typedef enum logic [1:0] {P_HDR, P_DATA, P_DONE} p_state_t;

    logic [1:0]           sync_q, sync_d;
    w_state_t             w_state_q, w_state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    p_state_t             p_state_q, p_state_d;
    logic                 mem_q, mem_d;
    logic [8:0]           addr_q, addr_d;
    logic [31:0]          data_q, data_d;
    logic [2:0]           k_q, k_d;
    logic [41:0]          data_out_q, data_out_d;
    logic                 valid_q, valid_d;
    logic                 error_q, error_d;
    logic                 rx_s;
    logic                 word_done;
    logic                 word_ferr;

`ifdef UART_BYTES_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);
    logic [TO_W-1:0] tcnt_q, tcnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) tcnt_q <= '0;
        else       tcnt_q <= tcnt_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CLKS;
`endif

    assign sync_d = {sync_q[0], rx};
    assign rx_s   = sync_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q     <= 2'b11;
            w_state_q  <= W_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            p_state_q  <= P_HDR;
            mem_q      <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            k_q        <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            w_state_q  <= w_state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            p_state_q  <= p_state_d;
            mem_q      <= mem_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            k_q        <= k_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
        end
    end

    // Word receiver: the stop sample lands mid-bit, so the next start edge is caught while idling.
    always_comb begin
        w_state_d = w_state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        word_done = 1'b0;
        word_ferr = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rx_s) w_state_d = W_START;
            end
            W_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    w_state_d = rx_s ? W_IDLE : W_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            W_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                    if (bit_q == BIT_LAST) w_state_d = W_STOP;
                    else                   bit_d     = bit_q + BIT_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            W_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d     = '0;
                    word_done = rx_s;
                    word_ferr = !rx_s;
                    w_state_d = W_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Packet deframer: data_out and valid are loaded together on entry to P_DONE.
    always_comb begin
        p_state_d  = p_state_q;
        mem_d      = mem_q;
        addr_d     = addr_q;
        data_d     = data_q;
        k_d        = k_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        error_d    = 1'b0;
`ifdef UART_BYTES_RX_TIMEOUT_EN
        tcnt_d     = '0;
`endif
        case (p_state_q)
            P_HDR: begin
                if (word_done) begin
                    if (shreg_q[11:10] == 2'b01) begin
                        mem_d     = shreg_q[9];
                        addr_d    = shreg_q[8:0];
                        data_d    = '0;
                        k_d       = '0;
                        p_state_d = P_DATA;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            P_DATA: begin
                if (word_done) begin
                    if (shreg_q[11:8] == 4'b0000) begin
                        for (int i = 0; i < 4; i++) begin
                            if (k_q == 3'(i)) data_d[8*i +: 8] = shreg_q[7:0];
                        end
                        k_d = k_q + 3'd1;
                        if (k_q == K_LAST) begin
                            data_out_d = {mem_q, addr_q, data_d};
                            valid_d    = 1'b1;
                            p_state_d  = P_DONE;
                        end
                    end else begin
                        error_d   = 1'b1;
                        p_state_d = P_HDR;
                    end
                end
`ifdef UART_BYTES_RX_TIMEOUT_EN
                if (w_state_q == W_IDLE) begin
                    if (tcnt_q == TO_LAST) begin
                        error_d   = 1'b1;
                        p_state_d = P_HDR;
                    end else begin
                        tcnt_d = tcnt_q + TO_W'(1);
                    end
                end
`endif
            end
            P_DONE: p_state_d = P_HDR;
            default: p_state_d = P_HDR;
        endcase
        if (word_ferr) begin
            error_d   = 1'b1;
            p_state_d = P_HDR;
        end
    end

    assign data_out = data_out_q;
    assign valid    = valid_q;
    assign error    = error_q;
    assign busy     = (w_state_q != W_IDLE) || (p_state_q != P_HDR);

endmodule
